// File: rtl/udp_loopback_pkg.sv
`default_nettype none
// udp_loopback_pkg -- shared beat layout, write-FSM states and pointer sizing for the UDP loopback buffer.
// Rev 1.0
package udp_loopback_pkg;

  localparam int DEF_DATA_WIDTH = 512;
  localparam int DEF_KEEP_WIDTH = DEF_DATA_WIDTH / 8;
  localparam int DEF_USER_WIDTH = 1;

  // Beat layout at the default geometry; the buffer builds the same field order at its own widths.
  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] data;
    logic [DEF_KEEP_WIDTH-1:0] keep;
    logic [DEF_USER_WIDTH-1:0] user;
    logic                      last;
  } beat_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DROP  = 2'd2
  } wr_state_t;

  // One extra bit beyond the address so that full and empty are distinguishable.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/udp_axis_beat_ram.sv
`default_nettype none
// udp_axis_beat_ram -- simple dual-port beat RAM, one write port, one read port with registered output.
// Rev 1.0
module udp_axis_beat_ram #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // rd_data holds its value while rd_en is low, so it doubles as a pipeline stage.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule
`default_nettype wire

// File: rtl/udp_axis_pkt_loopback_buf.sv
`default_nettype none
// udp_axis_pkt_loopback_buf -- store-and-forward AXI-Stream frame buffer; releases whole frames only, drops what cannot fit.
// Rev 1.0
module udp_axis_pkt_loopback_buf
  import udp_loopback_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = 64,
  parameter int USER_WIDTH = 1,
  parameter int DEPTH      = 64,
  parameter int MAX_PKTS   = 16
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]   s_axis_tkeep,
  input  logic [USER_WIDTH-1:0]   s_axis_tuser,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]   m_axis_tkeep,
  output logic [USER_WIDTH-1:0]   m_axis_tuser,
  output logic [31:0]             pkt_in_cnt,
  output logic [31:0]             pkt_out_cnt,
  output logic [31:0]             pkt_drop_cnt,
  output logic [$clog2(DEPTH):0]  occupancy
);

  localparam int PW  = ptr_width(DEPTH);
  localparam int AW  = PW - 1;
  localparam int PKW = $clog2(MAX_PKTS) + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [KEEP_WIDTH-1:0] keep;
    logic [USER_WIDTH-1:0] user;
    logic                  last;
  } beat_s;

  localparam int BW = $bits(beat_s);

  wr_state_t       state, state_nxt;
  logic [PW-1:0]   wr_ptr, commit_ptr, rd_ptr;
  logic [PKW-1:0]  pkts;
  logic            beat_in, full, pkts_full;
  logic            wr_en, commit, rewind, drop;

  logic            q_valid, out_valid, advance, rd_en, m_hs, out_last_hs;
  logic [BW-1:0]   ram_q;
  beat_s           in_beat, q_beat, out_beat;

  assign s_axis_tready = ~RESET;
  assign beat_in       = s_axis_tvalid & s_axis_tready;
  assign in_beat       = {s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast};
  assign full          = (wr_ptr - rd_ptr) == PW'(DEPTH);
  assign pkts_full     = pkts == PKW'(MAX_PKTS);

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    commit    = 1'b0;
    rewind    = 1'b0;
    drop      = 1'b0;
    if (beat_in) begin
      case (state)
        IDLE, WRITE: begin
          // No room for this beat (or no frame slot at frame start): abandon the whole frame.
          if (full || (state == IDLE && pkts_full)) begin
            rewind = 1'b1;
            if (s_axis_tlast) begin
              drop      = 1'b1;
              state_nxt = IDLE;
            end else begin
              state_nxt = DROP;
            end
          end else begin
            wr_en = 1'b1;
            if (s_axis_tlast) begin
              commit    = 1'b1;
              state_nxt = IDLE;
            end else begin
              state_nxt = WRITE;
            end
          end
        end
        DROP: begin
          if (s_axis_tlast) begin
            drop      = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr       <= '0;
      commit_ptr   <= '0;
      pkt_in_cnt   <= '0;
      pkt_drop_cnt <= '0;
    end else begin
      if (rewind)     wr_ptr <= commit_ptr;
      else if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (commit) begin
        commit_ptr <= wr_ptr + PW'(1);
        pkt_in_cnt <= pkt_in_cnt + 32'd1;
      end
      if (drop) pkt_drop_cnt <= pkt_drop_cnt + 32'd1;
    end
  end

  udp_axis_beat_ram #(
    .WIDTH (BW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (CLK),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (in_beat),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (ram_q)
  );

  assign q_beat      = ram_q;
  assign advance     = q_valid & (~out_valid | m_axis_tready);
  assign rd_en       = (rd_ptr != commit_ptr) & (~q_valid | advance);
  assign m_hs        = out_valid & m_axis_tready;
  assign out_last_hs = m_hs & out_beat.last;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd_ptr      <= '0;
      q_valid     <= 1'b0;
      out_valid   <= 1'b0;
      out_beat    <= '0;
      pkt_out_cnt <= '0;
    end else begin
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      if (rd_en)        q_valid <= 1'b1;
      else if (advance) q_valid <= 1'b0;
      if (advance) begin
        out_valid <= 1'b1;
        out_beat  <= q_beat;
      end else if (m_hs) begin
        out_valid <= 1'b0;
      end
      if (out_last_hs) pkt_out_cnt <= pkt_out_cnt + 32'd1;
    end
  end

  // A frame keeps its slot until its tlast leaves on the m side, so staged beats still count as resident.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pkts <= '0;
    end else begin
      case ({commit, out_last_hs})
        2'b10:   pkts <= pkts + PKW'(1);
        2'b01:   pkts <= pkts - PKW'(1);
        default: pkts <= pkts;
      endcase
    end
  end

  assign occupancy     = (commit_ptr - rd_ptr) + PW'(q_valid) + PW'(out_valid);
  assign m_axis_tvalid = out_valid;
  assign m_axis_tlast  = out_beat.last;
  assign m_axis_tdata  = out_beat.data;
  assign m_axis_tkeep  = out_beat.keep;
  assign m_axis_tuser  = out_beat.user;

endmodule
`default_nettype wire
